// File: rtl/keypad_time_loader.sv
// Keypad front end for the M:SS countdown timer. It buffers up to three BCD digits, checks the
// seconds-tens digit, and drives a one-cycle active-low load strobe into the down-counters.
module keypad_time_loader #(
  parameter int unsigned KEY_CLR      = 10,
  parameter int unsigned KEY_START    = 11,
  parameter int unsigned SEC_TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       timer_done,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic       loadn,
  output logic       running,
  output logic [1:0] digit_count,
  output logic       entry_error
);

  typedef enum logic [1:0] {StIdle, StEntry, StLoad, StRun} state_e;

  state_e state_q;

  logic is_digit, is_clr, is_start;

  always_comb begin
    is_digit = key_valid && (key_code <= 4'd9);
    is_clr   = key_valid && (key_code == 4'(KEY_CLR));
    is_start = key_valid && (key_code == 4'(KEY_START));
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= StIdle;
      sec_ones    <= 4'd0;
      sec_tens    <= 4'd0;
      min_ones    <= 4'd0;
      digit_count <= 2'd0;
      loadn       <= 1'b1;
      running     <= 1'b0;
      entry_error <= 1'b0;
    end else begin
      // Strobes default inactive, so each is at most one cycle wide.
      loadn       <= 1'b1;
      entry_error <= 1'b0;
      unique case (state_q)
        StIdle, StEntry: begin
          if (is_digit) begin
            if (digit_count != 2'd3) begin
              min_ones    <= sec_tens;
              sec_tens    <= sec_ones;
              sec_ones    <= key_code;
              digit_count <= digit_count + 2'd1;
              state_q     <= StEntry;
            end else begin
              entry_error <= 1'b1;
            end
          end else if (is_clr) begin
            sec_ones    <= 4'd0;
            sec_tens    <= 4'd0;
            min_ones    <= 4'd0;
            digit_count <= 2'd0;
            state_q     <= StIdle;
          end else if (is_start && (state_q == StEntry)) begin
            if (sec_tens > 4'(SEC_TENS_MAX)) begin
              entry_error <= 1'b1;
            end else begin
              state_q <= StLoad;
              loadn   <= 1'b0;
              running <= 1'b1;
            end
          end
        end
        // Keys and timer_done are deliberately ignored while the counters latch the digits.
        StLoad: state_q <= StRun;
        StRun: begin
          if (timer_done || is_clr) begin
            sec_ones    <= 4'd0;
            sec_tens    <= 4'd0;
            min_ones    <= 4'd0;
            digit_count <= 2'd0;
            running     <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_time_loader.sv
// Directed bench for keypad_time_loader; inputs driven on the falling edge, outputs sampled
// 1 time unit after the rising edge.
module tb_keypad_time_loader;

  localparam logic [3:0] KClr   = 4'd10;
  localparam logic [3:0] KStart = 4'd11;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       timer_done = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones;
  logic       loadn, running, entry_error;
  logic [1:0] digit_count;

  int n_tests = 0;
  int n_fail  = 0;

  keypad_time_loader dut (
    .clk        (clk),
    .clear      (clear),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .timer_done (timer_done),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .min_ones   (min_ones),
    .loadn      (loadn),
    .running    (running),
    .digit_count(digit_count),
    .entry_error(entry_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code, input logic done = 1'b0);
    @(negedge clk);
    key_valid  = 1'b1;
    key_code   = code;
    timer_done = done;
    @(posedge clk);
    #1;
    key_valid  = 1'b0;
    timer_done = 1'b0;
  endtask

  task automatic check_digits(input string tag, input logic [3:0] m, input logic [3:0] t,
                              input logic [3:0] o, input logic [1:0] cnt);
    check({tag, ".min"}, 32'(min_ones), 32'(m));
    check({tag, ".tens"}, 32'(sec_tens), 32'(t));
    check({tag, ".ones"}, 32'(sec_ones), 32'(o));
    check({tag, ".cnt"}, 32'(digit_count), 32'(cnt));
  endtask

  initial begin
    tick();
    tick();
    check_digits("reset", 4'd0, 4'd0, 4'd0, 2'd0);
    check("reset.loadn", 32'(loadn), 32'd1);
    check("reset.run", 32'(running), 32'd0);
    check("reset.err", 32'(entry_error), 32'd0);
    @(negedge clk);
    clear = 1'b0;

    // 1: enter 1:30 and load
    press(4'd1);
    check_digits("t1.k1", 4'd0, 4'd0, 4'd1, 2'd1);
    press(4'd3);
    press(4'd0);
    check_digits("t1.k3", 4'd1, 4'd3, 4'd0, 2'd3);
    press(KStart);
    check("t1.loadn_lo", 32'(loadn), 32'd0);
    check("t1.run_load", 32'(running), 32'd1);
    press(KClr);  // ignored in LOAD
    check("t1.loadn_hi", 32'(loadn), 32'd1);
    check("t1.run", 32'(running), 32'd1);
    check_digits("t1.hold", 4'd1, 4'd3, 4'd0, 2'd3);
    tick();
    check("t1.loadn_stay", 32'(loadn), 32'd1);
    press(4'd0, 1'b1);
    check("t1.done", 32'(running), 32'd0);

    // 2: seconds-tens of 7 rejected
    press(4'd2);
    press(4'd7);
    press(4'd5);
    press(KStart);
    check("t2.err", 32'(entry_error), 32'd1);
    check("t2.loadn", 32'(loadn), 32'd1);
    check_digits("t2.keep", 4'd2, 4'd7, 4'd5, 2'd3);
    tick();
    check("t2.err_1cyc", 32'(entry_error), 32'd0);
    check("t2.noload", 32'(loadn), 32'd1);
    press(KClr);
    check_digits("t2.clr", 4'd0, 4'd0, 4'd0, 2'd0);
    check("t2.clr_err", 32'(entry_error), 32'd0);

    // 3: fourth digit overflows
    press(4'd4);
    press(4'd5);
    press(4'd6);
    press(4'd7);
    check("t3.err", 32'(entry_error), 32'd1);
    check_digits("t3.keep", 4'd4, 4'd5, 4'd6, 2'd3);
    tick();
    check("t3.err_1cyc", 32'(entry_error), 32'd0);
    press(KClr);

    // 4: keys locked out during RUN
    press(4'd0);
    press(4'd4);
    press(4'd5);
    press(KStart);
    check("t4.loadn_lo", 32'(loadn), 32'd0);
    tick();
    press(4'd9);
    check_digits("t4.lock9", 4'd0, 4'd4, 4'd5, 2'd3);
    check("t4.err9", 32'(entry_error), 32'd0);
    press(KStart);
    check("t4.lockst", 32'(loadn), 32'd1);
    @(negedge clk);
    timer_done = 1'b1;
    @(posedge clk);
    #1;
    timer_done = 1'b0;
    check("t4.run", 32'(running), 32'd0);
    check_digits("t4.done", 4'd0, 4'd0, 4'd0, 2'd0);

    // 5: clear during LOAD, then START in IDLE
    press(4'd1);
    press(4'd2);
    press(4'd3);
    press(KStart);
    check("t5.loadn_lo", 32'(loadn), 32'd0);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    clear = 1'b0;
    check("t5.loadn", 32'(loadn), 32'd1);
    check("t5.run", 32'(running), 32'd0);
    check_digits("t5.zero", 4'd0, 4'd0, 4'd0, 2'd0);
    press(KStart);
    check("t5.idle_st", 32'(loadn), 32'd1);
    check("t5.idle_err", 32'(entry_error), 32'd0);
    check("t5.idle_run", 32'(running), 32'd0);

    // 6: START and timer_done together in RUN; unused code 14
    press(4'd1);
    press(4'd0);
    press(4'd0);
    press(KStart);
    tick();
    check("t6.running", 32'(running), 32'd1);
    press(KStart, 1'b1);
    check("t6.run", 32'(running), 32'd0);
    check("t6.loadn", 32'(loadn), 32'd1);
    check_digits("t6.idle", 4'd0, 4'd0, 4'd0, 2'd0);
    press(4'd14);
    check("t6.k14_cnt", 32'(digit_count), 32'd0);
    check("t6.k14_err", 32'(entry_error), 32'd0);
    press(4'd3);
    press(4'd14);
    check_digits("t6.k14_entry", 4'd0, 4'd0, 4'd3, 2'd1);
    check("t6.k14_err2", 32'(entry_error), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
